// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transfer arbiter: FSM states, requester
// count, timeout length and the layout of each requester's config byte.
package spi_arb_pkg;

  localparam int NUM_REQ        = 4;
  localparam int IDX_W          = 2;
  localparam int DATA_W         = 8;
  localparam int TIMEOUT_CYCLES = 1024;
  localparam int TMO_W          = 10;

  localparam int CFG_MODE_LSB = 0;
  localparam int CFG_MODE_W   = 2;
  localparam int CFG_DIV_LSB  = 2;
  localparam int CFG_DIV_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_RESPOND
  } arb_state_t;

  // Requester n owns byte lane n of the packed per-requester buses.
  function automatic logic [DATA_W-1:0] byte_lane(input logic [NUM_REQ*DATA_W-1:0] v,
                                                  input logic [IDX_W-1:0] idx);
    return v[{idx, 3'b000} +: DATA_W];
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational 4-way round-robin pick: the first set request found when
// scanning upward (with wrap) from the pointer wins.
module spi_rr_arbiter
  import spi_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               req_any
);

  // Scan from the farthest candidate down so the nearest one to ptr wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    req_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[ptr + IDX_W'(k)]) begin
        gnt_idx = ptr + IDX_W'(k);
        gnt     = NUM_REQ'(1) << (ptr + IDX_W'(k));
        req_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI master between four requesters with round-robin arbitration.
// Define SPI_ARB_TIMEOUT_EN to abort stalled transfers after 1024 cycles (err_o).
module spi_xfer_arbiter
  import spi_arb_pkg::*;
(
  input  logic        Pclk,
  input  logic        Preset,
  input  logic [3:0]  req_i,
  input  logic [31:0] tx_data_i,
  input  logic [31:0] cfg_i,
  output logic [3:0]  gnt_o,
  output logic [3:0]  done_o,
  output logic [7:0]  rx_data_o,
  output logic        err_o,
  input  logic        busy_i,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        write_enable,
  output logic [5:0]  clk_div,
  output logic [1:0]  mode
);

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, owner;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               tmo_hit, tmo_fire;
  logic               start_xfer, finish_xfer;
  logic [DATA_W-1:0]  cfg_sel;

  spi_rr_arbiter u_rr (
    .req     (req_i),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .req_any (arb_any)
  );

  assign cfg_sel = byte_lane(cfg_i, arb_idx);

  // A normal busy edge always beats a coincident timeout.
  always_comb begin
    state_nxt = state;
    tmo_fire  = 1'b0;
    case (state)
      ST_IDLE:      if (arb_any && !busy_i) state_nxt = ST_ISSUE;
      ST_ISSUE:     state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (busy_i) begin
          state_nxt = ST_WAIT_DONE;
        end else if (tmo_hit) begin
          state_nxt = ST_RESPOND;
          tmo_fire  = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy_i) begin
          state_nxt = ST_RESPOND;
        end else if (tmo_hit) begin
          state_nxt = ST_RESPOND;
          tmo_fire  = 1'b1;
        end
      end
      ST_RESPOND:   state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  assign start_xfer  = (state == ST_IDLE) && (state_nxt == ST_ISSUE);
  assign finish_xfer = (state != ST_RESPOND) && (state_nxt == ST_RESPOND);

  // write_enable is the registered start strobe launched from ISSUE.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      gnt_o        <= '0;
      done_o       <= '0;
      write_enable <= 1'b0;
      data_o       <= '0;
      rx_data_o    <= '0;
      clk_div      <= '0;
      mode         <= '0;
    end else begin
      state        <= state_nxt;
      write_enable <= (state == ST_ISSUE);
      done_o       <= '0;
      if (start_xfer) begin
        gnt_o   <= arb_gnt;
        owner   <= arb_idx;
        data_o  <= byte_lane(tx_data_i, arb_idx);
        clk_div <= cfg_sel[CFG_DIV_LSB +: CFG_DIV_W];
        mode    <= cfg_sel[CFG_MODE_LSB +: CFG_MODE_W];
      end
      if (finish_xfer) begin
        done_o    <= gnt_o;
        rx_data_o <= tmo_fire ? '0 : data_i;
      end
      if (state == ST_RESPOND) begin
        gnt_o  <= '0;
        rr_ptr <= owner + IDX_W'(1);
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             waiting;
  logic             err_q;

  assign waiting = (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);
  assign tmo_hit = waiting && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Any state change restarts the count, so each wait state gets a full window.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= finish_xfer && tmo_fire;
      if (state_nxt != state) tmo_cnt <= '0;
      else if (waiting)       tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign err_o = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Scoreboard bench for spi_xfer_arbiter: directed cases followed by randomized
// requester traffic, checked against a round-robin reference model.
module tb_spi_xfer_arbiter;

  logic        Pclk = 1'b0;
  logic        Preset;
  logic [3:0]  req_i;
  logic [31:0] tx_data_i, cfg_i;
  logic        busy_i;
  logic [7:0]  data_i;
  logic [3:0]  gnt_o, done_o;
  logic [7:0]  rx_data_o, data_o;
  logic        err_o, write_enable;
  logic [5:0]  clk_div;
  logic [1:0]  mode;

  logic        sl_busy, force_busy, slave_en, sl_kick, sl_rand;
  int          sl_len;
  logic [7:0]  sl_byte;
  assign busy_i = sl_busy | force_busy;

  int checks = 0;
  int failures = 0;

  logic [3:0]  req_seen;
  logic        busy_seen, rst_seen;
  logic [31:0] tx_seen, cfg_seen;
  logic [19:0] q_own[$];
  logic [8:0]  q_rx[$];
  int          m_ptr = 0;

  spi_xfer_arbiter dut (
    .Pclk(Pclk), .Preset(Preset), .req_i(req_i), .tx_data_i(tx_data_i), .cfg_i(cfg_i),
    .gnt_o(gnt_o), .done_o(done_o), .rx_data_o(rx_data_o), .err_o(err_o),
    .busy_i(busy_i), .data_i(data_i), .data_o(data_o), .write_enable(write_enable),
    .clk_div(clk_div), .mode(mode)
  );

  always #5 Pclk = ~Pclk;

  always @(posedge Pclk) begin
    req_seen  <= req_i;
    busy_seen <= busy_i;
    rst_seen  <= Preset;
    tx_seen   <= tx_data_i;
    cfg_seen  <= cfg_i;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lane(input logic [31:0] v, input int i);
    return v[i*8 +: 8];
  endfunction

  // Monitor: predicts each grant from the request snapshot and model pointer,
  // then pops and compares every completion.
  initial begin : monitor
    logic [3:0]  gnt_prev;
    logic [19:0] e;
    logic [8:0]  r;
    int w;
    gnt_prev = '0;
    forever begin
      @(negedge Pclk);
      if (rst_seen) begin
        gnt_prev = '0;
      end else begin
        if (gnt_o != 0 && gnt_prev == 0) begin
          w = -1;
          for (int k = 0; k < 4; k++)
            if (w < 0 && req_seen[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
          check("grant_had_request", {31'd0, w >= 0}, 32'd1);
          check("grant_bus_was_free", {31'd0, busy_seen}, 32'd0);
          if (w >= 0) begin
            check("grant_owner", gnt_o, 32'd1 << w);
            check("grant_data_o", data_o, lane(tx_seen, w));
            q_own.push_back({4'(32'd1 << w), lane(tx_seen, w), lane(cfg_seen, w)});
          end
        end
        gnt_prev = gnt_o;
        if (done_o != 0) begin
          check("done_expected", q_own.size(), (q_own.size() == 0) ? 32'd1 : q_own.size());
          if (q_own.size() != 0) begin
            e = q_own.pop_front();
            check("done_owner", done_o, e[19:16]);
            check("done_gnt_held", gnt_o, e[19:16]);
            check("done_data_o_held", data_o, e[15:8]);
            check("done_clk_div", clk_div, e[7:0] >> 2);
            check("done_mode", mode, e[7:0] & 8'h3);
            for (int k = 0; k < 4; k++) if (e[16 + k]) m_ptr = (k + 1) % 4;
          end
          check("done_rx_expected", {31'd0, q_rx.size() != 0}, 32'd1);
          if (q_rx.size() != 0) begin
            r = q_rx.pop_front();
            check("done_rx_data", rx_data_o, r[7:0]);
            check("done_err", err_o, r[8]);
          end
        end
      end
    end
  end

  // SPI master model: busy pulse after each start strobe, then a received byte.
  initial begin : slave
    int sl_wait, sl_hold, sl_phase;
    sl_busy = 1'b0; data_i = '0; sl_phase = 0; sl_wait = 0; sl_hold = 0;
    forever begin
      @(negedge Pclk);
      if (rst_seen) begin
        sl_phase = 0;
        sl_busy  = 1'b0;
      end else begin
        case (sl_phase)
          0: if ((write_enable && slave_en) || sl_kick) begin
               sl_kick  = 1'b0;
               sl_wait  = sl_rand ? $urandom_range(0, 2) : 0;
               sl_hold  = sl_rand ? $urandom_range(1, 6) : sl_len;
               sl_phase = 1;
             end
          1: if (sl_wait == 0) begin
               sl_busy = 1'b1; sl_phase = 2;
             end else sl_wait--;
          default: if (sl_hold <= 1) begin
               sl_busy = 1'b0;
               data_i  = sl_rand ? 8'($urandom) : sl_byte;
               q_rx.push_back({1'b0, data_i});
               sl_phase = 0;
             end else sl_hold--;
        endcase
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Pclk);
  endtask

  task automatic do_reset();
    @(negedge Pclk);
    Preset = 1'b1; req_i = '0; force_busy = 1'b0;
    @(negedge Pclk);
    check("rst_gnt", gnt_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_we", write_enable, 0);
    check("rst_data_o", data_o, 0);
    check("rst_rx", rx_data_o, 0);
    check("rst_cfg", {clk_div, mode}, 0);
    q_own.delete(); q_rx.delete(); m_ptr = 0;
    Preset = 1'b0;
  endtask

  task automatic wait_we(output int cnt);
    bit seen = 0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Pclk); cnt++;
      if (write_enable) begin seen = 1; break; end
    end
    check("write_enable_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_done_bit(input int n, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Pclk);
      if (done_o[n]) begin seen = 1; break; end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int cnt;
    bit saw;
    logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    Preset = 1'b1; req_i = '0; tx_data_i = '0; cfg_i = '0;
    force_busy = 1'b0; slave_en = 1'b1; sl_kick = 1'b0; sl_rand = 1'b0;
    sl_len = 5; sl_byte = 8'h3C;
    tick(3);
    do_reset();

    // Single transfer with known values and latency.
    tx_data_i = 32'h0000_00A5; cfg_i = 32'h0000_000D; req_i = 4'b0001;
    wait_we(cnt);
    check("t1_latency", cnt, 2);
    check("t1_gnt", gnt_o, 4'b0001);
    check("t1_data_o", data_o, 8'hA5);
    check("t1_clk_div", clk_div, 3);
    check("t1_mode", mode, 1);
    wait_done_bit(0, 40);
    check("t1_done", done_o, 4'b0001);
    check("t1_rx", rx_data_o, 8'h3C);
    req_i = '0;
    tick(1);
    check("t1_done_pulse", done_o, 0);
    tick(2);
    check("t1_rx_hold", rx_data_o, 8'h3C);

    // Request dropped and data changed after the grant.
    sl_byte = 8'hC3;
    tx_data_i[15:8] = 8'h5E; cfg_i[15:8] = 8'h92; req_i = 4'b0010;
    wait_we(cnt);
    req_i[1] = 1'b0; tx_data_i[15:8] = 8'h11; cfg_i[15:8] = 8'h22;
    wait_done_bit(1, 40);
    check("t2_done", done_o, 4'b0010);
    tick(2);

    // No grant while the bus is busy.
    force_busy = 1'b1; req_i = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("t3_no_gnt_busy", gnt_o, 0);
    end
    force_busy = 1'b0;
    wait_we(cnt);
    check("t3_latency", cnt, 2);
    wait_done_bit(2, 40);
    req_i = '0;
    tick(2);

    // Round-robin order with all requests held.
    do_reset();
    sl_rand = 1'b1; req_i = 4'b1111;
    begin
      logic [3:0] prev = '0;
      int k = 0;
      for (int i = 0; i < 300 && k < 5; i++) begin
        tick(1);
        if (gnt_o != 0 && prev == 0) begin
          check("t4_order", gnt_o, exp_order[k]);
          k++;
        end
        prev = gnt_o;
      end
      check("t4_grants", k, 5);
    end
    req_i = '0;
    wait_done_bit(0, 40);
    tick(2);

    // Reset in the middle of a transfer.
    sl_rand = 1'b0; sl_len = 10; req_i = 4'b0100;
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (busy_i) begin saw = 1; break; end
    end
    check("t5_busy_seen", {31'd0, saw}, 32'd1);
    tick(1);
    do_reset();
    req_i = 4'b1111;
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (gnt_o != 0) begin saw = 1; break; end
    end
    check("t5_gnt_after_reset", gnt_o, 4'b0001);
    req_i = '0;
    wait_done_bit(0, 40);
    tick(2);

    // Stalled master: abort with error, or hold the grant indefinitely.
    slave_en = 1'b0; req_i = 4'b1000;
    wait_we(cnt);
`ifdef SPI_ARB_TIMEOUT_EN
    q_rx.push_back({1'b1, 8'h00});
    cnt = 0; saw = 0;
    for (int i = 0; i < 1100; i++) begin
      tick(1); cnt++;
      if (done_o != 0) begin saw = 1; break; end
    end
    check("t6_timeout_done", done_o, 4'b1000);
    check("t6_timeout_cycles", cnt, 1024);
    check("t6_timeout_err", err_o, 1);
    check("t6_timeout_rx", rx_data_o, 0);
`else
    saw = 0;
    for (int i = 0; i < 1200; i++) begin
      tick(1);
      if (done_o != 0) saw = 1;
    end
    check("t6_no_done", {31'd0, saw}, 32'd0);
    check("t6_gnt_held", gnt_o, 4'b1000);
    sl_rand = 1'b0; sl_len = 2; sl_byte = 8'h5A; sl_kick = 1'b1;
    wait_done_bit(3, 40);
    check("t6_rx", rx_data_o, 8'h5A);
`endif
    req_i = '0; slave_en = 1'b1;
    tick(3);

    // Randomized traffic.
    sl_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      for (int n = 0; n < 4; n++) begin
        if (req_i[n] && done_o[n]) begin
          if ($urandom_range(0, 1) == 0) req_i[n] = 1'b0;
          else begin
            tx_data_i[n*8 +: 8] = 8'($urandom);
            cfg_i[n*8 +: 8] = 8'($urandom);
          end
        end else if (!req_i[n]) begin
          if ($urandom_range(0, 7) == 0) begin
            tx_data_i[n*8 +: 8] = 8'($urandom);
            cfg_i[n*8 +: 8] = 8'($urandom);
            req_i[n] = 1'b1;
          end
        end else if (!gnt_o[n]) begin
          if ($urandom_range(0, 63) == 0) req_i[n] = 1'b0;
        end else begin
          if ($urandom_range(0, 15) == 0) begin
            tx_data_i[n*8 +: 8] = 8'($urandom);
            cfg_i[n*8 +: 8] = 8'($urandom);
          end
          if ($urandom_range(0, 15) == 0) req_i[n] = 1'b0;
        end
      end
    end
    req_i = '0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (q_own.size() == 0 && gnt_o == 0) break;
    end
    check("drain_owner_queue", q_own.size(), 0);
    check("drain_rx_queue", q_rx.size(), 0);
    check("drain_gnt", gnt_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
